branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Bookkeeping companion to the GShare predictor: records every prediction issued at fetch (PC plus predicted direction) in order, and when the execute stage resolves the oldest in-flight branch, drives the predictor's update port (`update`, `updatePc`, `reality`) and flags mispredictions. It sits between fetch/GShare and execute. It is the write-back end of the predictor's predict/update interface.

## Interface

**Parameters**
- `DEPTH`, default 4: in-flight branch entries. Power of two, ≥ 2.
- `PC_W`, default 32: PC width.

**Ports**
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `predictValid` in 1: GShare produced a prediction this cycle (mirrors the predictor's `predict`).
- `predictPc` in PC_W: PC of the predicted branch.
- `prediction` in 1: predictor output for `predictPc`, valid in the same cycle as `predictValid`.
- `resolveValid` in 1: execute has resolved the oldest outstanding branch.
- `resolveTaken` in 1: actual direction (1 = taken).
- `flush` in 1: external pipeline flush; discards all entries.
- `update` out 1: registered one-cycle pulse to the GShare update port.
- `updatePc` out PC_W: PC for the update. Holds its last value when `update` = 0.
- `reality` out 1: actual outcome for the update. Holds its last value when `update` = 0.
- `mispredict` out 1: registered pulse, coincident with `update`, when the stored prediction ≠ `resolveTaken`.
- `count` out $clog2(DEPTH+1): number of valid entries.
- `full` out 1: `count` == DEPTH.
- `empty` out 1: `count` == 0.
- `error` out 1: sticky; set by an overflow enqueue or an underflow resolve. Cleared only by `reset`.

## Operation

- **Storage.** Circular FIFO of {pc, pred}. Read pointer and write pointer are log2(DEPTH) bits and wrap naturally. `count` is a separate register.
- **Enqueue.** On a rising edge with `predictValid` = 1 and the queue not full after this cycle's pop, write {`predictPc`, `prediction`} at the write pointer, then increment the write pointer.
- **Resolve.** On a rising edge with `resolveValid` = 1 and `count` > 0:
  - pop the head;
  - next cycle, drive `update` = 1, `updatePc` = head.pc, `reality` = `resolveTaken`;
  - drive `mispredict` = (head.pred ≠ `resolveTaken`) in the same cycle.
- **Mispredict squash.** A resolve that mispredicts also discards every younger entry: `count` → 0, write pointer := read pointer after the pop. An enqueue in that same cycle is dropped (wrong path) and does not set `error`.
- **flush.** `count` → 0 and write pointer := read pointer.
  - A resolve in the same cycle is still performed first, so its update is issued.
  - An enqueue in the same cycle is dropped.
- **Simultaneous enqueue + resolve.**
  - Both take effect and `count` is unchanged.
  - This is legal when full, because the pop frees a slot.
  - When empty, the resolve is an underflow and the enqueue proceeds.
- **Overflow.** `predictValid` while full with no pop: entry is dropped, state is unchanged, `error` := 1.
- **Underflow.** `resolveValid` while `count` = 0: no update is issued and `error` := 1.

## Timing

- Reset values: `update` = 0, `mispredict` = 0, `updatePc` = 0, `reality` = 0, `count` = 0, `empty` = 1, `full` = 0, `error` = 0, pointers = 0.
- Enqueue → visible in `count`/`empty`: 1 cycle after the edge.
- Resolve → `update`/`mispredict` pulse: asserted for exactly one cycle, starting the cycle after the resolving edge.
- Back-to-back resolves give back-to-back `update` pulses (throughput 1/cycle).
- Enqueue-to-earliest-resolve: the entry must be in the queue before its resolve edge, so minimum 1 cycle.
- `full`, `empty` and `error` are driven from registers (no combinational path from inputs).
- Reset asserted mid-operation: all entries are lost immediately (asynchronous), and any pending `update` pulse is suppressed.

## Test plan

1. **Reset, then two predictions.** Reset; enqueue pc = 0x10 (pred 1), then pc = 0x14 (pred 0) → `count` = 2.
   - Resolve taken = 1 → `update` = 1, `updatePc` = 0x10, `reality` = 1, `mispredict` = 0.
   - Resolve taken = 0 → `updatePc` = 0x14, `mispredict` = 0, `empty` = 1.
2. **Mispredict squash.** Enqueue pcs 0x20 (pred 0), 0x24, 0x28. Resolve taken = 1 while enqueuing 0x2C.
   - Next cycle: `update` = 1, `updatePc` = 0x20, `reality` = 1, `mispredict` = 1.
   - `count` = 0 and `error` = 0 (the 0x2C enqueue is dropped).
3. **Full + simultaneous.** Fill DEPTH = 4 entries (0x40..0x4C); `full` = 1.
   - Enqueue 0x50 together with a resolve (correct) → `count` stays 4, `updatePc` = 0x40.
   - Three further resolves return 0x44, 0x48, 0x4C; the final resolve returns 0x50, proving wrap-around.
4. **Overflow/underflow.**
   - With 4 entries, enqueue without a resolve → `count` = 4 and `error` = 1.
   - After reset, resolve while empty → no `update` pulse and `error` = 1.
5. **Flush.** Enqueue 0x60 and 0x64. Flush together with a resolve (taken = 0, pred 0).
   - `update` pulses with `updatePc` = 0x60; `count` = 0.
   - A later enqueue of 0x68, then a resolve → `updatePc` = 0x68.
6. **Async reset mid-stream.** Assert `reset` between clock edges while `count` = 3 and a resolve is pending.
   - `count` = 0 and `update` = 0 immediately.
   - No pulse on the following edges.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction tracker driving the GShare update port
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         predictValid,
  input  logic [PC_W-1:0]              predictPc,
  input  logic                         prediction,
  input  logic                         resolveValid,
  input  logic                         resolveTaken,
  input  logic                         flush,
  output logic                         update,
  output logic [PC_W-1:0]              updatePc,
  output logic                         reality,
  output logic                         mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [AW-1:0]    rd_ptr, wr_ptr;

  logic            pop, push, squash, mis, overflow, underflow;
  logic [AW-1:0]   rd_next, wr_next;
  logic [CW-1:0]   count_next;

  always_comb begin
    pop       = resolveValid && (count != '0);
    underflow = resolveValid && (count == '0);
    mis       = pop && (pred_mem[rd_ptr] != resolveTaken);
    squash    = mis || flush;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    push      = predictValid && !squash && ((count != DEPTH_C) || pop);
    overflow  = predictValid && !squash && (count == DEPTH_C) && !pop;
    rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
    wr_next   = wr_ptr;
    count_next = count;
    if (squash) begin
      wr_next    = rd_next;
      count_next = '0;
    end else begin
      if (push) wr_next = wr_ptr + AW'(1);
      if (push && !pop) count_next = count + CW'(1);
      else if (pop && !push) count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= predictPc;
      pred_mem[wr_ptr] <= prediction;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      error      <= 1'b0;
      update     <= 1'b0;
      mispredict <= 1'b0;
      updatePc   <= '0;
      reality    <= 1'b0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      full       <= (count_next == DEPTH_C);
      empty      <= (count_next == '0);
      error      <= error | overflow | underflow;
      update     <= pop;
      mispredict <= mis;
      if (pop) begin
        updatePc <= pc_mem[rd_ptr];
        reality  <= resolveTaken;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - table-driven checks for branch_resolve_queue
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        predictValid = 1'b0;
  logic [31:0] predictPc = '0;
  logic        prediction = 1'b0;
  logic        resolveValid = 1'b0;
  logic        resolveTaken = 1'b0;
  logic        flush = 1'b0;
  logic        update, reality, mispredict, full, empty, error;
  logic [31:0] updatePc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  branch_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .predictValid(predictValid), .predictPc(predictPc), .prediction(prediction),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken), .flush(flush),
    .update(update), .updatePc(updatePc), .reality(reality), .mispredict(mispredict),
    .count(count), .full(full), .empty(empty), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    logic        rv;
    logic        rt;
    logic        fl;
    logic        e_upd;
    logic [31:0] e_pc;
    logic        e_real;
    logic        e_mis;
    int          e_cnt;
    logic        e_full;
    logic        e_empty;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic pv, logic [31:0] pc, logic pr, logic rv,
                              logic rt, logic fl, logic e_upd, logic [31:0] e_pc,
                              logic e_real, logic e_mis, int e_cnt, logic e_full,
                              logic e_empty, logic e_err);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.pr = pr; v.rv = rv; v.rt = rt; v.fl = fl;
    v.e_upd = e_upd; v.e_pc = e_pc; v.e_real = e_real; v.e_mis = e_mis; v.e_cnt = e_cnt;
    v.e_full = e_full; v.e_empty = e_empty; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pr,
                       input logic rv, input logic rt, input logic fl);
    predictValid = pv; predictPc = pc; prediction = pr;
    resolveValid = rv; resolveTaken = rt; flush = fl;
  endtask

  initial begin
    //          rst pv pc      pr rv rt fl | upd pc      real mis cnt full empty err
    // Two predictions, both resolved correctly
    vecs.push_back(mk(0, 1, 32'h10, 1, 0, 0, 0,  0, 32'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h14, 0, 0, 0, 0,  0, 32'h00, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h10, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 0, 0,  1, 32'h14, 0, 0, 0, 0, 1, 0));
    // Mispredict squashes younger entries and the same-cycle enqueue
    vecs.push_back(mk(0, 1, 32'h20, 0, 0, 0, 0,  0, 32'h14, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h24, 1, 0, 0, 0,  0, 32'h14, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h28, 1, 0, 0, 0,  0, 32'h14, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h2C, 1, 1, 1, 0,  1, 32'h20, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0,  0, 32'h20, 1, 0, 0, 0, 1, 0));
    // Fill, enqueue+resolve while full, drain with wrap-around
    vecs.push_back(mk(0, 1, 32'h40, 1, 0, 0, 0,  0, 32'h20, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h44, 1, 0, 0, 0,  0, 32'h20, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h48, 1, 0, 0, 0,  0, 32'h20, 1, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4C, 1, 0, 0, 0,  0, 32'h20, 1, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h50, 1, 1, 1, 0,  1, 32'h40, 1, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h44, 1, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h48, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h4C, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h50, 1, 0, 0, 0, 1, 0));
    // Overflow
    vecs.push_back(mk(0, 1, 32'h70, 0, 0, 0, 0,  0, 32'h50, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h74, 0, 0, 0, 0,  0, 32'h50, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h78, 0, 0, 0, 0,  0, 32'h50, 1, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h7C, 0, 0, 0, 0,  0, 32'h50, 1, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 0,  0, 32'h50, 1, 0, 4, 1, 0, 1));
    // Underflow right after reset
    vecs.push_back(mk(1, 0, 32'h00, 0, 1, 1, 0,  0, 32'h00, 0, 0, 0, 0, 1, 1));
    // Flush together with a correct resolve
    vecs.push_back(mk(1, 1, 32'h60, 0, 0, 0, 0,  0, 32'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h64, 0, 0, 0, 0,  0, 32'h00, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 0, 1,  1, 32'h60, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h68, 1, 0, 0, 0,  0, 32'h60, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 1, 0,  1, 32'h68, 1, 0, 0, 0, 1, 0));

    pulse_reset();
    #1;
    chk("rst.update", 0, 32'(update), 32'd0);
    chk("rst.mispredict", 0, 32'(mispredict), 32'd0);
    chk("rst.updatePc", 0, updatePc, 32'd0);
    chk("rst.reality", 0, 32'(reality), 32'd0);
    chk("rst.count", 0, 32'(count), 32'd0);
    chk("rst.empty", 0, 32'(empty), 32'd1);
    chk("rst.full", 0, 32'(full), 32'd0);
    chk("rst.error", 0, 32'(error), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) pulse_reset();
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pc, vecs[i].pr, vecs[i].rv, vecs[i].rt, vecs[i].fl);
      @(posedge clk);
      #1;
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("update", i, 32'(update), 32'(vecs[i].e_upd));
      chk("updatePc", i, updatePc, vecs[i].e_pc);
      chk("reality", i, 32'(reality), 32'(vecs[i].e_real));
      chk("mispredict", i, 32'(mispredict), 32'(vecs[i].e_mis));
      chk("count", i, 32'(count), 32'(vecs[i].e_cnt));
      chk("full", i, 32'(full), 32'(vecs[i].e_full));
      chk("empty", i, 32'(empty), 32'(vecs[i].e_empty));
      chk("error", i, 32'(error), 32'(vecs[i].e_err));
    end

    // Async reset between edges with three entries and a resolve pending
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 32'h90 + 32'(4 * k), 1, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 1, 0);
    chk("a6.count_before", 0, 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("a6.count_async", 0, 32'(count), 32'd0);
    chk("a6.update_async", 0, 32'(update), 32'd0);
    chk("a6.empty_async", 0, 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    chk("a6.update_e1", 0, 32'(update), 32'd0);
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("a6.update_e2", 0, 32'(update), 32'd0);
    chk("a6.error", 0, 32'(error), 32'd0);

    // Async reset kills an update pulse already on the port
    @(negedge clk);
    drive(1, 32'hA0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0, 0, 0);
    chk("a6b.update_on", 0, 32'(update), 32'd1);
    chk("a6b.updatePc_on", 0, updatePc, 32'hA0);
    #2 reset = 1'b1;
    #1;
    chk("a6b.update_killed", 0, 32'(update), 32'd0);
    chk("a6b.updatePc_cleared", 0, updatePc, 32'd0);
    #1 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
